// File: rtl/mem_request_ctrl.sv
// rtl/mem_request_ctrl.sv - arbitrates core fetch and load/store requests onto the single-ported ram
module mem_request_ctrl #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int DM_LATENCY    = 2,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              imem_ack,
    output logic              dmem_ack,
    output logic              fetch_err,
    output logic              stall,
    output logic              ram_read_enable,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address_IM,
    output logic [ADDR_W-1:0] ram_address_DM,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_instr_out,
    input  logic              ram_pc_enable
);

    localparam logic [DATA_W-1:0] NOP        = DATA_W'(32'h0000_0013);
    localparam logic [7:0]        DM_LAST    = 8'(DM_LATENCY - 1);
    localparam logic [7:0]        FETCH_LAST = 8'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t     state;
    logic [7:0] cnt;

    // Enables are registered and set on the entry edge, so they are high for
    // every cycle spent in DATA/FETCH and low in IDLE.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state            <= IDLE;
            cnt              <= '0;
            instr            <= NOP;
            dmem_rdata       <= '0;
            imem_ack         <= 1'b0;
            dmem_ack         <= 1'b0;
            fetch_err        <= 1'b0;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_address_IM   <= '0;
            ram_address_DM   <= '0;
            ram_data_in      <= '0;
        end else begin
            imem_ack  <= 1'b0;
            dmem_ack  <= 1'b0;
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmem_read || dmem_write) begin
                        state            <= DATA;
                        cnt              <= '0;
                        ram_address_DM   <= dmem_addr;
                        ram_data_in      <= dmem_wdata;
                        ram_write_enable <= dmem_write;
                        ram_read_enable  <= ~dmem_write;
                    end else if (imem_req) begin
                        state           <= FETCH;
                        cnt             <= '0;
                        ram_address_IM  <= imem_addr;
                        ram_read_enable <= 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DM_LAST) begin
                        if (!ram_write_enable)
                            dmem_rdata <= ram_data_out;
                        dmem_ack         <= 1'b1;
                        state            <= IDLE;
                        cnt              <= '0;
                        ram_read_enable  <= 1'b0;
                        ram_write_enable <= 1'b0;
                        ram_data_in      <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FETCH: begin
                    // A pc_enable arriving on the timeout edge still counts as success.
                    if (ram_pc_enable) begin
                        instr           <= ram_instr_out;
                        imem_ack        <= 1'b1;
                        state           <= IDLE;
                        cnt             <= '0;
                        ram_read_enable <= 1'b0;
                    end else if (cnt == FETCH_LAST) begin
                        instr           <= NOP;
                        imem_ack        <= 1'b1;
                        fetch_err       <= 1'b1;
                        state           <= IDLE;
                        cnt             <= '0;
                        ram_read_enable <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    cnt              <= '0;
                    ram_read_enable  <= 1'b0;
                    ram_write_enable <= 1'b0;
                    ram_data_in      <= '0;
                end
            endcase
        end
    end

    // In the ack cycle the acknowledged request is not considered pending.
    assign stall = (state != IDLE) ||
                   (imem_req && !imem_ack) ||
                   ((dmem_read || dmem_write) && !dmem_ack);

endmodule

// File: tb/tb_mem_request_ctrl.sv
// tb/tb_mem_request_ctrl.sv - table-driven bench for mem_request_ctrl
module tb_mem_request_ctrl;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        imem_req = 1'b0;
    logic [4:0]  imem_addr = '0;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [4:0]  dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] instr, dmem_rdata;
    logic        imem_ack, dmem_ack, fetch_err, stall;
    logic        ram_read_enable, ram_write_enable;
    logic [4:0]  ram_address_IM, ram_address_DM;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out = '0;
    logic [31:0] ram_instr_out = '0;
    logic        ram_pc_enable = 1'b0;

    int tests = 0;
    int failed = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    mem_request_ctrl #(.ADDR_W(5), .DATA_W(32), .DM_LATENCY(2), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .nRst(nRst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .instr(instr), .dmem_rdata(dmem_rdata),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .fetch_err(fetch_err), .stall(stall),
        .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .ram_address_IM(ram_address_IM), .ram_address_DM(ram_address_DM),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_instr_out(ram_instr_out), .ram_pc_enable(ram_pc_enable)
    );

    always #5 clk = ~clk;

    // kind: 0 fetch, 1 load, 2 store, 3 load+store; pc_delay 0 means never
    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          pc_delay;
        int          exp_lat;
        int          exp_en;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0;
        int en = 0;
        int bad = 0;
        int stall_bad = 0;
        bit got = 0;
        @(negedge clk);
        imem_req      = (v.kind == 0);
        dmem_read     = (v.kind == 1 || v.kind == 3);
        dmem_write    = (v.kind == 2 || v.kind == 3);
        imem_addr     = v.addr;
        dmem_addr     = v.addr;
        dmem_wdata    = v.wdata;
        ram_data_out  = v.rdata;
        ram_instr_out = v.rdata;
        ram_pc_enable = 1'b0;
        #1;
        if (!stall) stall_bad++;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (v.kind == 0) begin
                if (ram_read_enable) begin
                    en++;
                    if (ram_address_IM !== v.addr || ram_write_enable) bad++;
                end
            end else if (v.kind == 1) begin
                if (ram_read_enable) begin
                    en++;
                    if (ram_address_DM !== v.addr || ram_write_enable) bad++;
                end
            end else begin
                if (ram_write_enable) begin
                    en++;
                    if (ram_address_DM !== v.addr || ram_data_in !== v.wdata || ram_read_enable) bad++;
                end
                if (ram_read_enable) bad++;
            end
            if (imem_ack || dmem_ack) begin
                got = 1;
                chk($sformatf("v%0d latency", idx), cyc, v.exp_lat);
                chk($sformatf("v%0d enable_cycles", idx), en, v.exp_en);
                chk($sformatf("v%0d ram_side", idx), bad, 0);
                chk($sformatf("v%0d result", idx), (v.kind == 0) ? instr : dmem_rdata, v.exp_res);
                chk($sformatf("v%0d ack_err", idx), {imem_ack, dmem_ack, fetch_err},
                    (v.kind == 0) ? {1'b1, 1'b0, v.exp_err} : 3'b010);
                chk($sformatf("v%0d stall_busy", idx), stall_bad, 0);
                chk($sformatf("v%0d stall_ack", idx), stall, 1'b0);
            end else begin
                if (!stall) stall_bad++;
                if (v.kind == 0 && v.pc_delay != 0 && en == v.pc_delay) ram_pc_enable = 1'b1;
            end
        end
        if (!got) chk($sformatf("v%0d ack_timeout", idx), 0, 1);
        imem_req = 1'b0;
        dmem_read = 1'b0;
        dmem_write = 1'b0;
        ram_pc_enable = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d pulse_end", idx), {imem_ack, dmem_ack, fetch_err, stall}, 4'b0000);
    endtask

    initial begin
        int d_cyc, i_cyc, both, ack_seen;
        vecs[0] = '{0, 5'd1,  32'h0,         32'h0050_0093, 2,  3,  2,  32'h0050_0093, 1'b0};
        vecs[1] = '{1, 5'd2,  32'h0,         32'hDEAD_BEEF, 0,  3,  2,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{2, 5'd4,  32'h1234_5678, 32'hAAAA_5555, 0,  3,  2,  32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{3, 5'd31, 32'hCAFE_F00D, 32'h1111_1111, 0,  3,  2,  32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{0, 5'd0,  32'h0,         32'h0000_0033, 1,  2,  1,  32'h0000_0033, 1'b0};
        vecs[5] = '{0, 5'd7,  32'h0,         32'h0040_0113, 0,  16, 15, NOP,           1'b1};
        vecs[6] = '{0, 5'd9,  32'h0,         32'h00A0_0513, 15, 16, 15, 32'h00A0_0513, 1'b0};
        vecs[7] = '{1, 5'd0,  32'h0,         32'h8000_0001, 0,  3,  2,  32'h8000_0001, 1'b0};

        #12;
        chk("reset_outputs",
            {dmem_rdata, imem_ack, dmem_ack, fetch_err, stall, ram_read_enable, ram_write_enable,
             ram_address_IM, ram_address_DM, ram_data_in}, '0);
        chk("reset_instr", instr, NOP);
        @(negedge clk);
        nRst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Arbitration: data wins, fetch follows right after the data ack.
        @(negedge clk);
        ram_pc_enable = 1'b1;
        ram_instr_out = 32'h00C0_0193;
        ram_data_out  = 32'h5A5A_5A5A;
        imem_addr = 5'd6;
        dmem_addr = 5'd8;
        imem_req  = 1'b1;
        dmem_read = 1'b1;
        d_cyc = 0; i_cyc = 0; both = 0;
        for (int c = 1; c <= 20 && i_cyc == 0; c++) begin
            @(negedge clk);
            if (ram_read_enable && ram_write_enable) both++;
            if (dmem_ack) begin d_cyc = c; dmem_read = 1'b0; end
            if (imem_ack) begin i_cyc = c; imem_req = 1'b0; end
        end
        ram_pc_enable = 1'b0;
        chk("arb_dmem_ack_cycle", d_cyc, 3);
        chk("arb_imem_ack_cycle", i_cyc, 5);
        chk("arb_both_enables", both, 0);
        chk("arb_instr", instr, 32'h00C0_0193);
        chk("arb_rdata", dmem_rdata, 32'h5A5A_5A5A);
        @(negedge clk);

        // Asynchronous reset in the middle of a fetch.
        imem_req  = 1'b1;
        imem_addr = 5'd3;
        repeat (3) @(negedge clk);
        chk("rst_pre_fetch", {ram_read_enable, ram_address_IM}, {1'b1, 5'd3});
        #2 nRst = 1'b0;
        #1;
        chk("rst_async_enables", {ram_read_enable, ram_write_enable, imem_ack, fetch_err}, 4'b0000);
        chk("rst_async_instr", instr, NOP);
        imem_req = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        ack_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_ack || dmem_ack || stall || ram_read_enable) ack_seen++;
        end
        chk("rst_no_ack_after", ack_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
